mem_lsu: RTL



---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 39 +++
 rtl/mem_lsu.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the mem_lsu memory stage.
// State, access-size and fault-cause encodings plus the alignment rule.
package mem_pkg;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    typedef enum logic [1:0] {FLT_NONE, FLT_MISALIGN, FLT_TIMEOUT} fault_t;

    // An access is misaligned when any address bit below its natural size is set.
    function automatic logic misaligned(size_t sz, logic [2:0] lo);
        case (sz)
            SZ_H:    return lo[0];
            SZ_W:    return |lo[1:0];
            SZ_D:    return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: moves store data onto its byte lanes and pulls load data
// back off them, zero- or sign-extending to XLEN.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int LW   = $clog2(NB)
) (
    input  size_t            size_i,
    input  logic [LW-1:0]    lane_i,
    input  logic             ld_unsigned_i,
    input  logic [XLEN-1:0]  store_data_i,
    input  logic [XLEN-1:0]  data_read_i,
    output logic [NB-1:0]    byte_en_o,
    output logic [XLEN-1:0]  data_write_o,
    output logic [XLEN-1:0]  load_data_o
);

    logic [NB-1:0]   span;
    logic [XLEN-1:0] shifted, mask, top;
    logic [6:0]      nbits;
    logic            sgn;

    // Spans wider than the remaining lanes simply fall off the top; a
    // full-width load yields an all-ones mask so no extension happens.
    always_comb begin
        span         = ~({NB{1'b1}} << (4'd1 << size_i));
        byte_en_o    = span << lane_i;
        data_write_o = store_data_i << {lane_i, 3'b000};
        shifted      = data_read_i >> {lane_i, 3'b000};
        nbits        = 7'd8 << size_i;
        mask         = ~({XLEN{1'b1}} << nbits);
        top          = mask & ~(mask >> 1);
        sgn          = ~ld_unsigned_i & (|(shifted & top));
        load_data_o  = (shifted & mask) | ({XLEN{sgn}} & ~mask);
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory stage between execute and writeback. Resolves branches,
// issues MMIO loads/stores and stalls until dack.
// MEM_FAULT_EN: enables misalignment and timeout fault detection.
module mem_lsu
    import mem_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int REG_AW  = 5,
    parameter  int TIMEOUT = 255,
    localparam int NB      = XLEN / 8,
    localparam int LW      = $clog2(NB)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              jal_flush_i,
    input  logic              regwrite_i,
    input  logic              load_i,
    input  logic              store_i,
    input  logic              jal_i,
    input  logic              jalr_i,
    input  logic              branch_cond_i,
    input  logic [1:0]        size_i,
    input  logic              ld_unsigned_i,
    input  logic [XLEN-1:0]   target_i,
    input  logic [XLEN-1:0]   result_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [REG_AW-1:0] regD_i,
    output logic [REG_AW-1:0] regD_ex_o,
    output logic [XLEN-1:0]   regD_val_ex_o,
    output logic              regwrite_ex_o,
    output logic              branch_flush_o,
    output logic [XLEN-1:0]   b_target_o,
    output logic              stall_o,
    output logic              regwriteF_o,
    output logic              jalF_o,
    output logic [REG_AW-1:0] regDF_o,
    output logic [XLEN-1:0]   targetF_o,
    output logic [XLEN-1:0]   regdataF_o,
    output logic              req_pulse_o,
    output logic              rw_o,
    output logic [XLEN-1:0]   addr_o,
    output logic [XLEN-1:0]   data_write_o,
    output logic [NB-1:0]     byte_en_o,
    input  logic [XLEN-1:0]   data_read_i,
    input  logic              dack_i,
    output logic              fault_valid_o,
    output logic [1:0]        fault_cause_o,
    output logic [XLEN-1:0]   fault_addr_o
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, wdata_q, acc_addr, al_wd, al_ld;
    logic [NB-1:0]     be_q, al_be;
    logic              rw_q, mis, nop;
    logic              regwriteF_q, regwriteF_d, jalF_q, jalF_d;
    logic [REG_AW-1:0] regDF_q, regDF_d;
    logic [XLEN-1:0]   targetF_q, targetF_d, regdataF_q, regdataF_d;

`ifdef MEM_FAULT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    fault_t            fault_d, fault_cause_q;
    logic              fault_valid_q;
    logic [XLEN-1:0]   fault_addr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    assign mis = (load_i | store_i) & misaligned(size_t'(size_i), result_i[2:0]);
`else
    assign mis = 1'b0;
`endif

    assign acc_addr   = {result_i[XLEN-1:LW], {LW{1'b0}}};
    assign b_target_o = target_i;

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .size_i        (size_t'(size_i)),
        .lane_i        (result_i[LW-1:0]),
        .ld_unsigned_i (ld_unsigned_i),
        .store_data_i  (store_data_i),
        .data_read_i   (data_read_i),
        .byte_en_o     (al_be),
        .data_write_o  (al_wd),
        .load_data_o   (al_ld)
    );

    // Next state, MMIO request, stall, and next writeback fields (also forwarded).
    always_comb begin
        state_d        = state_q;
        req_pulse_o    = 1'b0;
        rw_o           = load_i;
        addr_o         = acc_addr;
        data_write_o   = al_wd;
        byte_en_o      = al_be;
        stall_o        = 1'b0;
        branch_flush_o = 1'b0;
        nop            = 1'b0;
        regdataF_d     = result_i;
`ifdef MEM_FAULT_EN
        fault_d        = FLT_NONE;
`endif
        case (state_q)
            IDLE: begin
                if (jal_flush_i) begin
                    nop = 1'b1;
                end else if (branch_cond_i) begin
                    branch_flush_o = 1'b1;
                end else if (mis) begin
                    nop = 1'b1;
`ifdef MEM_FAULT_EN
                    fault_d = FLT_MISALIGN;
`endif
                end else if (load_i | store_i) begin
                    req_pulse_o = 1'b1;
                    if (dack_i) begin
                        if (load_i) regdataF_d = al_ld;
                    end else begin
                        stall_o = 1'b1;
                        nop     = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                rw_o         = rw_q;
                addr_o       = addr_q;
                data_write_o = wdata_q;
                byte_en_o    = be_q;
                if (dack_i) begin
                    state_d = IDLE;
                    if (rw_q) regdataF_d = al_ld;
                end
`ifdef MEM_FAULT_EN
                else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = IDLE;
                    nop     = 1'b1;
                    fault_d = FLT_TIMEOUT;
                end
`endif
                else begin
                    stall_o = 1'b1;
                    nop     = 1'b1;
                end
            end
        endcase
        regwriteF_d = nop ? 1'b0 : regwrite_i;
        jalF_d      = nop ? 1'b0 : (jal_i | jalr_i);
        regDF_d     = nop ? '0 : regD_i;
        targetF_d   = nop ? '0 : target_i;
        if (nop) regdataF_d = '0;
    end

    assign regwrite_ex_o = regwriteF_d;
    assign regD_ex_o     = regDF_d;
    assign regD_val_ex_o = regdataF_d;

    // State, request hold registers (captured while idle) and writeback registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rw_q        <= 1'b0;
            regwriteF_q <= 1'b0;
            jalF_q      <= 1'b0;
            regDF_q     <= '0;
            targetF_q   <= '0;
            regdataF_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                addr_q  <= acc_addr;
                wdata_q <= al_wd;
                be_q    <= al_be;
                rw_q    <= load_i;
            end
            regwriteF_q <= regwriteF_d;
            jalF_q      <= jalF_d;
            regDF_q     <= regDF_d;
            targetF_q   <= targetF_d;
            regdataF_q  <= regdataF_d;
        end
    end

    assign regwriteF_o = regwriteF_q;
    assign jalF_o      = jalF_q;
    assign regDF_o     = regDF_q;
    assign targetF_o   = targetF_q;
    assign regdataF_o  = regdataF_q;

`ifdef MEM_FAULT_EN
    // Wait counter runs only while staying in WAIT; any exit clears it.
    always_comb cnt_d = (state_q == WAIT && state_d == WAIT) ? cnt_q + 1'b1 : '0;

    // Fault report is a one-cycle pulse registered alongside the NOP.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q         <= '0;
            fault_valid_q <= 1'b0;
            fault_cause_q <= FLT_NONE;
            fault_addr_q  <= '0;
        end else begin
            cnt_q         <= cnt_d;
            fault_valid_q <= (fault_d != FLT_NONE);
            fault_cause_q <= fault_d;
            fault_addr_q  <= (fault_d != FLT_NONE) ? result_i : '0;
        end
    end

    assign fault_valid_o = fault_valid_q;
    assign fault_cause_o = fault_cause_q;
    assign fault_addr_o  = fault_addr_q;
`else
    assign fault_valid_o = 1'b0;
    assign fault_cause_o = 2'b00;
    assign fault_addr_o  = '0;
`endif

endmodule
